// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus between the PC sequencer and instruction memory.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata, imem_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata, imem_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner: fetch -> hold -> execute -> next PC, with traps on
// misaligned taken targets and fetch bus errors.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC     = 32'h0000_0100,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_sequencer_if.master     bus,
  output logic [31:0]        Instr,
  output logic               InstrValid,
  input  logic               ExecDone,
  input  logic               NextPCSrc,
  input  logic [31:0]        ALURes,
  input  logic               Stall,
  output logic [31:0]        PC,
  output logic [31:0]        PCPlus4,
  output logic               Trap,
  output logic [1:0]         TrapCause
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        ivalid_q, ivalid_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] tgt_s;

  assign PCPlus4 = pc_q + 32'd4;

  // JALR-style target: bit0 is dropped so only bit1 can be misaligned.
  assign tgt_s = NextPCSrc ? (ALURes & 32'hFFFF_FFFE) : PCPlus4;

  // Next-state and registered-output computation; every output is a flop so
  // it reflects the state being entered.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    req_d    = req_q;
    ivalid_d = ivalid_q;
    trap_d   = 1'b0;
    cause_d  = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (!Stall) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (bus.imem_rvalid && bus.imem_err) begin
          cause_d = 2'b10;
          state_d = ST_TRAP;
          req_d   = 1'b0;
          trap_d  = 1'b1;
        end else if (bus.imem_rvalid) begin
          instr_d  = bus.imem_rdata;
          state_d  = ST_EXEC;
          req_d    = 1'b0;
          ivalid_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (ExecDone && ALIGN_CHECK && NextPCSrc && tgt_s[1]) begin
          cause_d  = 2'b01;
          state_d  = ST_TRAP;
          ivalid_d = 1'b0;
          trap_d   = 1'b1;
        end else if (ExecDone) begin
          pc_d     = tgt_s;
          ivalid_d = 1'b0;
          if (!Stall) begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_TRAP: begin
        pc_d    = TRAP_PC;
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        req_d    = 1'b0;
        ivalid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops imem_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      req_q    <= 1'b0;
      ivalid_q <= 1'b0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      ivalid_q <= ivalid_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign Instr         = instr_q;
  assign InstrValid    = ivalid_q;
  assign PC            = pc_q;
  assign Trap          = trap_q;
  assign TrapCause     = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_EXEC = 2, PH_TRAP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instr, PC, PCPlus4, ALURes;
  logic        InstrValid, ExecDone, NextPCSrc, Stall, Trap;
  logic [1:0]  TrapCause;

  int tests = 0;
  int fails = 0;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .Instr(Instr), .InstrValid(InstrValid), .ExecDone(ExecDone),
    .NextPCSrc(NextPCSrc), .ALURes(ALURes), .Stall(Stall),
    .PC(PC), .PCPlus4(PCPlus4), .Trap(Trap), .TrapCause(TrapCause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what phase the instruction cycle is in and the
  // architectural PC / held instruction / last trap cause.
  int          m_ph;
  logic [31:0] m_pc, m_instr;
  logic [1:0]  m_cause;

  function automatic logic [31:0] next_pc(input logic take, input logic [31:0] alu,
                                          input logic [31:0] pc);
    return take ? {alu[31:1], 1'b0} : pc + 32'd4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph    <= PH_IDLE;
      m_pc    <= RESET_PC;
      m_instr <= 32'h0000_0013;
      m_cause <= 2'b00;
    end else if (m_ph == PH_IDLE) begin
      m_ph <= Stall ? PH_IDLE : PH_FETCH;
    end else if (m_ph == PH_FETCH) begin
      if (bus.imem_rvalid && bus.imem_err) begin
        m_cause <= 2'b10;
        m_ph    <= PH_TRAP;
      end else if (bus.imem_rvalid) begin
        m_instr <= bus.imem_rdata;
        m_ph    <= PH_EXEC;
      end
    end else if (m_ph == PH_EXEC) begin
      if (ExecDone && NextPCSrc && next_pc(NextPCSrc, ALURes, m_pc)[1]) begin
        m_cause <= 2'b01;
        m_ph    <= PH_TRAP;
      end else if (ExecDone) begin
        m_pc <= next_pc(NextPCSrc, ALURes, m_pc);
        m_ph <= Stall ? PH_IDLE : PH_FETCH;
      end
    end else begin
      m_pc <= TRAP_PC;
      m_ph <= PH_IDLE;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_req",   {31'd0, bus.imem_req}, {31'd0, m_ph == PH_FETCH});
      chk("m_addr",  bus.imem_addr, m_pc);
      chk("m_pc",    PC, m_pc);
      chk("m_pc4",   PCPlus4, m_pc + 32'd4);
      chk("m_valid", {31'd0, InstrValid}, {31'd0, m_ph == PH_EXEC});
      chk("m_instr", Instr, m_instr);
      chk("m_trap",  {31'd0, Trap}, {31'd0, m_ph == PH_TRAP});
      chk("m_cause", {30'd0, TrapCause}, {30'd0, m_cause});
    end
  end

  task automatic clear_inputs();
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.imem_err = 1'b0;
    ExecDone = 1'b0; NextPCSrc = 1'b0; ALURes = 32'h0; Stall = 1'b0;
  endtask

  // Waits for a fetch, checks its address, answers after lat idle cycles.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                          input logic err, input int lat);
    int n = 0;
    while (!bus.imem_req && n < 50) begin @(negedge clk); n++; end
    chk("fetch_timeout", {31'd0, n < 50}, 32'd1);
    chk("fetch_addr", bus.imem_addr, exp_addr);
    repeat (lat) @(negedge clk);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = word; bus.imem_err = err;
    @(negedge clk);
    bus.imem_rvalid = 1'b0; bus.imem_err = 1'b0;
  endtask

  // Waits for EXEC, checks the held word, then signals completion.
  task automatic do_exec(input logic [31:0] exp_instr, input logic take,
                         input logic [31:0] alu, input logic st);
    int n = 0;
    while (!InstrValid && n < 50) begin @(negedge clk); n++; end
    chk("exec_timeout", {31'd0, n < 50}, 32'd1);
    chk("exec_instr", Instr, exp_instr);
    ExecDone = 1'b1; NextPCSrc = take; ALURes = alu; Stall = st;
    @(negedge clk);
    ExecDone = 1'b0; NextPCSrc = 1'b0;
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("rst_pc",    PC, 32'h0000_0000);
    chk("rst_instr", Instr, 32'h0000_0013);
    chk("rst_cause", {30'd0, TrapCause}, 32'd0);
    rst_n = 1'b1;

    // Sequential step from reset.
    do_fetch(32'h0, 32'h0050_0093, 1'b0, 1);
    do_exec(32'h0050_0093, 1'b0, 32'h0, 1'b0);
    do_fetch(32'h4, 32'h1111_0013, 1'b0, 0);
    do_exec(32'h1111_0013, 1'b1, 32'h40, 1'b0);
    // Taken target with bit0 set: bit0 cleared, no trap.
    do_fetch(32'h40, 32'h2222_0013, 1'b0, 0);
    do_exec(32'h2222_0013, 1'b1, 32'h81, 1'b0);
    chk("b0_trap", {31'd0, Trap}, 32'd0);
    chk("b0_pc", PC, 32'h80);
    do_fetch(32'h80, 32'h3333_0013, 1'b0, 2);
    do_exec(32'h3333_0013, 1'b1, 32'h40, 1'b0);
    // Misaligned taken target traps.
    do_fetch(32'h40, 32'h4444_0013, 1'b0, 0);
    do_exec(32'h4444_0013, 1'b1, 32'h82, 1'b0);
    chk("mis_trap", {31'd0, Trap}, 32'd1);
    chk("mis_cause", {30'd0, TrapCause}, 32'd1);
    chk("mis_pc", PC, 32'h40);
    @(negedge clk);
    chk("mis_trap_pulse", {31'd0, Trap}, 32'd0);
    chk("mis_pc_after", PC, 32'h100);
    // Fetch error traps without entering EXEC.
    do_fetch(32'h100, 32'hDEAD_BEEF, 1'b1, 0);
    chk("ferr_trap", {31'd0, Trap}, 32'd1);
    chk("ferr_cause", {30'd0, TrapCause}, 32'd2);
    chk("ferr_valid", {31'd0, InstrValid}, 32'd0);
    chk("ferr_instr", Instr, 32'h4444_0013);
    @(negedge clk);
    chk("ferr_pc", PC, 32'h100);
    // Stall held for three cycles at EXEC exit.
    do_fetch(32'h100, 32'h5555_0013, 1'b0, 0);
    do_exec(32'h5555_0013, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
      if (i < 2) @(negedge clk);
    end
    Stall = 1'b0;
    @(negedge clk);
    chk("stall_release_req", {31'd0, bus.imem_req}, 32'd1);
    do_fetch(32'h104, 32'h6666_0013, 1'b0, 0);
    // PC wrap.
    do_exec(32'h6666_0013, 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("wrap_pc4", PCPlus4, 32'h0000_0000);
    do_fetch(32'hFFFF_FFFC, 32'h7777_0013, 1'b0, 0);
    do_exec(32'h7777_0013, 1'b0, 32'h0, 1'b0);
    chk("wrap_trap", {31'd0, Trap}, 32'd0);
    // Reset in the middle of an outstanding fetch.
    chk("midrst_req_before", {31'd0, bus.imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("midrst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("midrst_pc", PC, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    do_fetch(RESET_PC, 32'h0050_0093, 1'b0, 0);

    // Randomized traffic; the model comparison does the checking.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.imem_rvalid = ($urandom_range(0, 2) == 0);
      bus.imem_err    = ($urandom_range(0, 7) == 0);
      bus.imem_rdata  = $urandom;
      ExecDone        = ($urandom_range(0, 2) == 0);
      NextPCSrc       = $urandom_range(0, 1) == 1;
      ALURes          = $urandom;
      Stall           = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    clear_inputs();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
